// File: rtl/vpu_sram_rd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sram_rd_responder_pkg
// Description : Shared defaults and types for the VPU SRAM read responder.
//               Holds the SRAM geometry defaults, the port-id width, the
//               response-pipeline tag type and a round-robin helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vpu_sram_rd_responder_pkg;

  localparam int SRAM_NUM_PORTS      = 4;
  localparam int SRAM_BANK_CNT_LG2   = 2;
  localparam int SRAM_BANK_DEPTH_LG2 = 10;
  localparam int SRAM_DATA_WIDTH     = 128;

  // Width of a port index; kept at least 1 so a single-port build still has
  // a legal vector.
  localparam int PORT_ID_W = (SRAM_NUM_PORTS > 1) ? $clog2(SRAM_NUM_PORTS) : 1;

  // One entry of the per-bank response pipeline.
  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port_id;
  } rd_tag_t;

  // Next round-robin position after cur, wrapping at n.
  function automatic logic [PORT_ID_W-1:0] rr_next(input logic [PORT_ID_W-1:0] cur,
                                                   input int n);
    if (int'(cur) >= n - 1) begin
      return '0;
    end
    return cur + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpu_sram_rd_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vpu_rr_arbiter
// Description : Round-robin arbiter with advance-on-grant pointer.
//               The winner is the first requester at or after the pointer,
//               wrapping; the pointer moves to winner+1 only when a grant is
//               issued.
// Ports       : clk, rst_n (sync, active-low)
//               req      - request vector
//               grant    - one-hot grant (combinational)
//               winner   - index of the granted requester
//               granted  - any grant this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_rr_arbiter
  import vpu_sram_rd_responder_pkg::*;
#(
  parameter int NUM_REQ = SRAM_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic [PORT_ID_W-1:0] winner,
  output logic                 granted
);

  localparam logic [PORT_ID_W:0] NUM_REQ_W = (PORT_ID_W + 1)'(NUM_REQ);

  logic [PORT_ID_W-1:0] r_ptr;

  // Scan NUM_REQ positions starting at the pointer; the extra bit in the
  // running sum lets the wrap be done by a single subtraction.
  always_comb begin
    logic [PORT_ID_W:0]   w_sum;
    logic [PORT_ID_W-1:0] w_idx;
    grant   = '0;
    winner  = r_ptr;
    granted = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PORT_ID_W + 1)'(k);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      w_idx = w_sum[PORT_ID_W-1:0];
      if (!granted && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        winner       = w_idx;
        granted      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (granted) begin
      r_ptr <= rr_next(winner, NUM_REQ);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vpu_sram_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : vpu_sram_rd_responder
// Description : Responder side of the VPU SRAM read-port protocol. Arbitrates
//               the source ports round-robin per bank, issues single-beat
//               reads to the bank macros and returns the data to the
//               requesting port as a one-cycle rvalid pulse.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               req_i/ack_o       - per-port request / same-cycle grant
//               rid_i, addr_i     - per-port target bank and word address
//               reb_i, rlast_i    - per-port read enable (low) / last beat
//               rdata_o, rvalid_o - per-port registered data / valid pulse
//               bank_ceb_o, bank_addr_o, bank_rdata_i - bank macro interface
//               err_o             - sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module vpu_sram_rd_responder
  import vpu_sram_rd_responder_pkg::*;
#(
  parameter int NUM_PORTS      = SRAM_NUM_PORTS,
  parameter int BANK_CNT_LG2   = SRAM_BANK_CNT_LG2,
  parameter int BANK_DEPTH_LG2 = SRAM_BANK_DEPTH_LG2,
  parameter int DATA_WIDTH     = SRAM_DATA_WIDTH,
  parameter int BANK_LATENCY   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_PORTS-1:0]                 req_i,
  output logic [NUM_PORTS-1:0]                 ack_o,
  input  logic [NUM_PORTS*BANK_CNT_LG2-1:0]    rid_i,
  input  logic [NUM_PORTS*BANK_DEPTH_LG2-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0]                 reb_i,
  input  logic [NUM_PORTS-1:0]                 rlast_i,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      rdata_o,
  output logic [NUM_PORTS-1:0]                 rvalid_o,
  output logic [(2**BANK_CNT_LG2)-1:0]         bank_ceb_o,
  output logic [(2**BANK_CNT_LG2)*BANK_DEPTH_LG2-1:0] bank_addr_o,
  input  logic [(2**BANK_CNT_LG2)*DATA_WIDTH-1:0]     bank_rdata_i,
  output logic                                 err_o
);

  localparam int BANK_CNT   = 2**BANK_CNT_LG2;
  // Stage 0 is the cycle the bank is enabled; the last stage is the cycle the
  // bank data is valid and gets captured.
  localparam int PIPE_DEPTH = BANK_LATENCY + 1;

  logic [BANK_CNT_LG2-1:0]   w_port_rid   [NUM_PORTS];
  logic [BANK_DEPTH_LG2-1:0] w_port_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]     w_bank_rdata [BANK_CNT];
  logic [NUM_PORTS-1:0]      w_bank_grant [BANK_CNT];
  rd_tag_t                   w_tail       [BANK_CNT];
  logic [NUM_PORTS-1:0]      w_eligible;
  logic [NUM_PORTS-1:0]      w_ack;

  logic [NUM_PORTS-1:0]      r_rvalid;
  logic [DATA_WIDTH-1:0]     r_rdata [NUM_PORTS];
  logic                      r_err;

  // Requests are masked during reset so no ack is raised and no arbiter
  // pointer moves while the block is held in reset.
  assign w_eligible = req_i & ~reb_i & {NUM_PORTS{rst_n}};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_port_rid[p]  = rid_i[p*BANK_CNT_LG2 +: BANK_CNT_LG2];
    assign w_port_addr[p] = addr_i[p*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2];
    assign rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = r_rdata[p];
  end

  for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
    logic [NUM_PORTS-1:0]      w_req;
    logic [PORT_ID_W-1:0]      w_winner;
    logic                      w_granted;
    logic                      r_ceb;
    logic [BANK_DEPTH_LG2-1:0] r_addr;
    rd_tag_t                   r_pipe [PIPE_DEPTH];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cand
      assign w_req[p] = w_eligible[p] && (w_port_rid[p] == BANK_CNT_LG2'(b));
    end

    vpu_rr_arbiter #(
      .NUM_REQ (NUM_PORTS)
    ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (w_req),
      .grant   (w_bank_grant[b]),
      .winner  (w_winner),
      .granted (w_granted)
    );

    // Bank command and response tag pipeline. The address register only
    // loads on a grant so the bank address holds between accesses.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_ceb  <= 1'b1;
        r_addr <= '0;
        for (int k = 0; k < PIPE_DEPTH; k++) begin
          r_pipe[k] <= '0;
        end
      end else begin
        r_ceb <= ~w_granted;
        if (w_granted) begin
          r_addr <= w_port_addr[w_winner];
        end
        r_pipe[0] <= '{valid: w_granted, port_id: w_winner};
        for (int k = 1; k < PIPE_DEPTH; k++) begin
          r_pipe[k] <= r_pipe[k-1];
        end
      end
    end

    assign w_tail[b]       = r_pipe[PIPE_DEPTH-1];
    assign w_bank_rdata[b] = bank_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign bank_ceb_o[b]   = r_ceb;
    assign bank_addr_o[b*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2] = r_addr;
  end

  // A port targets a single bank, so OR-ing the per-bank grants never
  // produces more than one grant per port.
  always_comb begin
    w_ack = '0;
    for (int b = 0; b < BANK_CNT; b++) begin
      w_ack = w_ack | w_bank_grant[b];
    end
  end

  assign ack_o = w_ack;

  // Response return. Fixed latency plus one grant per port per cycle means
  // two banks can never complete for the same port in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_rdata[p] <= '0;
      end
    end else begin
      r_rvalid <= '0;
      for (int b = 0; b < BANK_CNT; b++) begin
        if (w_tail[b].valid) begin
          r_rvalid[w_tail[b].port_id] <= 1'b1;
          r_rdata[w_tail[b].port_id]  <= w_bank_rdata[b];
        end
      end
    end
  end

  assign rvalid_o = r_rvalid;

  // Sticky error: a request without read enable, or a served request that
  // does not mark itself as the last beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((|(req_i & reb_i)) || (|(req_i & ~reb_i & ~rlast_i))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vpu_sram_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vpu_sram_rd_responder
// Description : Self-checking bench for vpu_sram_rd_responder. Hosts queue
//               reads per port; a reference model arbitrates per bank and
//               schedules expected responses; a bank memory model answers
//               the DUT bank interface.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vpu_sram_rd_responder;

  localparam int NP  = 4;
  localparam int NB  = 4;
  localparam int AW  = 10;
  localparam int DW  = 128;
  localparam int LAT = 3;   // ack to rvalid, BANK_LATENCY = 1

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NP-1:0]    req_i, reb_i, rlast_i, ack_o, rvalid_o;
  logic [NP*2-1:0]  rid_i;
  logic [NP*AW-1:0] addr_i;
  logic [NP*DW-1:0] rdata_o;
  logic [NB-1:0]    bank_ceb_o;
  logic [NB*AW-1:0] bank_addr_o;
  logic [NB*DW-1:0] bank_rdata_i;
  logic             err_o;

  always #5 clk = ~clk;

  vpu_sram_rd_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .ack_o        (ack_o),
    .rid_i        (rid_i),
    .addr_i       (addr_i),
    .reb_i        (reb_i),
    .rlast_i      (rlast_i),
    .rdata_o      (rdata_o),
    .rvalid_o     (rvalid_o),
    .bank_ceb_o   (bank_ceb_o),
    .bank_addr_o  (bank_addr_o),
    .bank_rdata_i (bank_rdata_i),
    .err_o        (err_o)
  );

  // Bank macros: one-cycle read latency.
  logic [DW-1:0] mem [NB][1<<AW];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!bank_ceb_o[b]) bank_rdata_i[b*DW +: DW] <= mem[b][bank_addr_o[b*AW +: AW]];
    end
  end

  typedef struct {
    logic [1:0]    rid;
    logic [AW-1:0] addr;
    bit            reb;
    bit            rlast;
  } rd_t;

  rd_t hq [NP][$];

  // Reference model state
  int               ptr [NB];
  bit               due_v [8][NP];
  logic [DW-1:0]    due_d [8][NP];
  logic [DW-1:0]    exp_rdata [NP];
  logic [NB-1:0]    exp_ceb;
  logic [NB*AW-1:0] exp_baddr;
  bit               exp_err;
  int               cyc;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int p, input int rid, input int addr, input bit reb = 1'b0,
                      input bit rlast = 1'b1);
    rd_t r;
    r.rid = 2'(rid); r.addr = AW'(addr); r.reb = reb; r.rlast = rlast;
    hq[p].push_back(r);
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    for (int s = 0; s < 8; s++) for (int p = 0; p < NP; p++) due_v[s][p] = 1'b0;
    for (int p = 0; p < NP; p++) exp_rdata[p] = '0;
    exp_ceb = '1; exp_baddr = '0; exp_err = 1'b0; cyc = 0;
  endtask

  // One clock cycle: drive the host heads, predict, compare, advance.
  task automatic cycle_step();
    logic [NP-1:0]    m_ack, m_rv;
    logic [NB-1:0]    n_ceb;
    logic [NB*AW-1:0] n_addr;
    bit               n_err, found;
    int               p, slot;
    for (int q = 0; q < NP; q++) begin
      if (hq[q].size() > 0) begin
        req_i[q] = 1'b1; reb_i[q] = hq[q][0].reb; rlast_i[q] = hq[q][0].rlast;
        rid_i[q*2 +: 2] = hq[q][0].rid; addr_i[q*AW +: AW] = hq[q][0].addr;
      end else begin
        req_i[q] = 1'b0; reb_i[q] = 1'b1; rlast_i[q] = 1'b1;
        rid_i[q*2 +: 2] = 2'($urandom); addr_i[q*AW +: AW] = AW'($urandom);
      end
    end
    #3;
    m_ack = '0; n_ceb = '1; n_addr = exp_baddr; n_err = exp_err;
    for (int q = 0; q < NP; q++) begin
      if (hq[q].size() > 0 && (hq[q][0].reb || !hq[q][0].rlast)) n_err = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
        p = (ptr[b] + k) % NP;
        if (!found && hq[p].size() > 0 && !hq[p][0].reb && int'(hq[p][0].rid) == b) begin
          found = 1'b1;
          m_ack[p] = 1'b1;
          n_ceb[b] = 1'b0;
          n_addr[b*AW +: AW] = hq[p][0].addr;
          slot = (cyc + LAT) % 8;
          due_v[slot][p] = 1'b1;
          due_d[slot][p] = mem[b][hq[p][0].addr];
          ptr[b] = (p + 1) % NP;
        end
      end
    end
    slot = cyc % 8;
    m_rv = '0;
    for (int q = 0; q < NP; q++) begin
      if (due_v[slot][q]) begin
        m_rv[q] = 1'b1; exp_rdata[q] = due_d[slot][q]; due_v[slot][q] = 1'b0;
      end
    end
    chk("ack", DW'(ack_o), DW'(m_ack));
    chk("rvalid", DW'(rvalid_o), DW'(m_rv));
    for (int q = 0; q < NP; q++) chk($sformatf("rdata%0d", q), rdata_o[q*DW +: DW], exp_rdata[q]);
    chk("bank_ceb", DW'(bank_ceb_o), DW'(exp_ceb));
    chk("bank_addr", DW'(bank_addr_o), DW'(exp_baddr));
    chk("err", DW'(err_o), DW'(exp_err));
    @(posedge clk); #1;
    for (int q = 0; q < NP; q++) if (m_ack[q]) void'(hq[q].pop_front());
    exp_ceb = n_ceb; exp_baddr = n_addr; exp_err = n_err; cyc++;
  endtask

  function automatic bit busy();
    for (int q = 0; q < NP; q++) if (hq[q].size() > 0) return 1'b1;
    for (int s = 0; s < 8; s++) for (int q = 0; q < NP; q++) if (due_v[s][q]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      cycle_step();
      n++;
    end
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected_below=%0d", n, budget);
    end
    repeat (2) cycle_step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int q = 0; q < NP; q++) hq[q].delete();
    req_i = '0; reb_i = '1; rlast_i = '1;
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_ack", DW'(ack_o), '0);
      chk("rst_rvalid", DW'(rvalid_o), '0);
      for (int q = 0; q < NP; q++) chk($sformatf("rst_rdata%0d", q), rdata_o[q*DW +: DW], '0);
      chk("rst_ceb", DW'(bank_ceb_o), DW'({NB{1'b1}}));
      chk("rst_addr", DW'(bank_addr_o), '0);
      chk("rst_err", DW'(err_o), '0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    req_i = '0; reb_i = '1; rlast_i = '1; rid_i = '0; addr_i = '0; bank_rdata_i = '0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < (1<<AW); a++) mem[b][a] = {$urandom, $urandom, $urandom, $urandom};
    mem[1][5] = {16{8'hA5}};
    model_reset();
    do_reset(2);

    // 1: single read, port0 -> bank1 addr 0x005
    push(0, 1, 5);
    run_until_idle(20);

    // 2: four ports contend for bank2
    for (int q = 0; q < NP; q++) push(q, 2, 16 + q);
    run_until_idle(30);

    // 3: all four banks in parallel
    for (int q = 0; q < NP; q++) push(q, q, 100 + q);
    run_until_idle(20);

    // 4: back-to-back reads on one port
    for (int a = 0; a < 8; a++) push(1, 3, a);
    run_until_idle(30);

    // 5a: request without read enable is never served and sets the error
    push(2, 0, 7, 1'b1, 1'b1);
    repeat (4) cycle_step();
    hq[2].delete();
    repeat (4) cycle_step();
    chk("err_sticky", DW'(err_o), DW'(1));

    // 5b: non-last beat is served and flags an error
    do_reset(1);
    push(3, 2, 33, 1'b0, 1'b0);
    run_until_idle(20);
    chk("err_rlast", DW'(err_o), DW'(1));

    // 6: reset with reads in flight; afterwards pointer is back at port 0
    do_reset(1);
    push(1, 0, 1); push(2, 0, 2); push(3, 0, 3);
    repeat (3) cycle_step();
    do_reset(2);
    repeat (6) cycle_step();
    push(3, 0, 9); push(0, 0, 8);
    run_until_idle(20);

    // Randomized traffic
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      for (int q = 0; q < NP; q++) begin
        if (hq[q].size() == 0 && ($urandom % 3) != 0)
          push(q, int'($urandom % NB), int'($urandom % (1<<AW)), 1'b0, ($urandom % 50) != 0);
      end
      cycle_step();
    end
    run_until_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vpu_sram_rd_responder.md
Name: vpu_sram_rd_responder

Overview:
Responder end of the VPU SRAM read-port protocol (req/ack, rid, addr, reb, rlast, rdata, rvalid). It serves NUM_PORTS source-port controllers that share a banked SRAM. Each cycle it arbitrates round-robin per bank, issues the single-beat read to the bank macro, and routes the returned data back to the requesting port with a one-cycle rvalid pulse. It sits inside the SRAM interconnect, between the source-port controllers and the bank macros.

Parameters:
NUM_PORTS, 4, number of requesting read ports
BANK_CNT_LG2, 2, log2 of bank count; BANK_CNT = 2**BANK_CNT_LG2
BANK_DEPTH_LG2, 10, per-bank word address width
DATA_WIDTH, 128, SRAM word width
BANK_LATENCY, 1, cycles from bank_ceb_o low to valid bank_rdata_i (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req_i  in  NUM_PORTS  per-port read request, held until ack
ack_o  out  NUM_PORTS  per-port grant, combinational, same cycle as req
rid_i  in  NUM_PORTS*BANK_CNT_LG2  per-port target bank id
addr_i  in  NUM_PORTS*BANK_DEPTH_LG2  per-port word address
reb_i  in  NUM_PORTS  per-port read enable, active-low
rlast_i  in  NUM_PORTS  per-port last beat; always 1 (single-beat)
rdata_o  out  NUM_PORTS*DATA_WIDTH  per-port read data, registered
rvalid_o  out  NUM_PORTS  per-port one-cycle data-valid pulse
bank_ceb_o  out  BANK_CNT  bank chip enable, active-low, registered
bank_addr_o  out  BANK_CNT*BANK_DEPTH_LG2  bank address, registered
bank_rdata_i  in  BANK_CNT*DATA_WIDTH  bank read data
err_o  out  1  sticky protocol error

Behaviour:
- Reset values: ack_o=0, rvalid_o=0, rdata_o=0, bank_ceb_o=all 1, bank_addr_o=0, err_o=0. All RR pointers=0. All response pipeline stages invalid.
- Eligible request: req_i[p]=1 and reb_i[p]=0.
  - req_i[p]=1 with reb_i[p]=1: never acked; err_o set (sticky until reset).
  - rlast_i[p]=0 on an eligible request: still served; err_o set.
- Arbitration: independent per bank b.
  - Candidates are eligible ports with rid_i[p]==b.
  - Winner is the first candidate at or after ptr[b], wrapping modulo NUM_PORTS.
  - On a grant, ptr[b] <= winner+1 (wraps); otherwise ptr[b] holds.
  - A port addresses one bank, so at most one grant per port per cycle.
  - Different banks grant in parallel.
- Cycle T (grant):
  - ack_o[p]=1 in T only. The host drops req at T+1.
  - A requester that loses keeps req held; ack_o stays 0 (stall), with no timeout.
- Cycle T+1: bank_ceb_o[b]=0 and bank_addr_o[b]=latched addr for exactly one cycle. Otherwise ceb=1 and addr holds its last value.
- Response pipeline:
  - A per-bank shift register of depth BANK_LATENCY+1 carries {valid, port_id}.
  - At T+1+BANK_LATENCY, bank_rdata_i[b] is captured.
  - At T+2+BANK_LATENCY, rdata_o[p]=captured word and rvalid_o[p]=1 for one cycle.
  - Total ack-to-rvalid latency is BANK_LATENCY+2 (3 at default).
- rdata_o[p] holds its last value when rvalid_o[p]=0.
- Back-to-back operation:
  - A port may re-request the cycle after ack; each bank sustains 1 read/cycle.
  - A port's responses return in grant order, because latency is fixed and there is one grant per port per cycle.
  - No two responses can target the same port in the same cycle.
- Simultaneous events: rvalid_o[p] and ack_o[p] for a new request may coincide; both are honored.
- Reset mid-operation: all in-flight reads are discarded; no rvalid_o is emitted after reset deasserts for reads granted before reset.
- No backpressure on rvalid; hosts always accept.

Decomposition:
- VPU_PKG holds SRAM_BANK_CNT_LG2, SRAM_BANK_DEPTH_LG2 and SRAM_DATA_WIDTH as parameter defaults.
- VPU_PKG also holds the localparam PORT_ID_W = $clog2(NUM_PORTS).
- VPU_PKG also holds a packed typedef rd_tag_t = {valid, port_id}.
- Sub-module vpu_rr_arbiter: NUM_PORTS request vector in, one-hot grant out, internal pointer, advance-on-grant. Instantiate one per bank via generate.

Test Plan:
1. Single read: port0 req, rid=1, addr=0x005, reb=0, rlast=1 at T; bank1 returns 0xA5..A5.
   -> ack_o[0] at T; bank_ceb_o[1]=0 and bank_addr_o[1]=0x005 at T+1; rvalid_o[0]=1 with rdata_o[0]=0xA5..A5 at T+3; err_o=0.
2. Bank conflict: ports 0–3 all req bank 2, held.
   -> acks in order p0,p1,p2,p3 on consecutive cycles; rvalid_o in the same order 3 cycles after each ack.
3. Parallel banks: p0→bank0, p1→bank1, p2→bank2, p3→bank3 in the same cycle.
   -> all four acks in T; all four rvalid_o at T+3 with per-bank data correct.
4. Back-to-back: p1 issues 8 reads to bank3, addr 0..7, re-requesting the cycle after each ack.
   -> 8 consecutive acks; 8 consecutive rvalid_o[1] with data matching addr 0..7 in order.
5. Protocol error: p2 req with reb=1.
   -> never acked, no bank access, err_o=1 next cycle and stays 1.
   Separately, rlast=0 with reb=0 -> read served normally, err_o=1.
6. Reset mid-op: 3 reads in flight; rst_n=0 for 2 cycles.
   -> all outputs at reset values; no rvalid_o afterwards; a fresh req after reset completes with latency 3 and RR pointer at 0.
